// File: rtl/scan_bank_pkg.sv
// Shared types and default sizes for the scan bank controller.
package scan_bank_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int LEN_W_DEF = 5;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_CLEAR = 2'b01,
    OP_LOAD  = 2'b10,
    OP_SHIFT = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_LD   = 3'd2,
    ST_SHF  = 3'd3,
    ST_FIN  = 3'd4
  } state_e;
endpackage

// File: rtl/scan_bank_ctrl_if.sv
// Command handshake between a requester and the scan bank controller.
interface scan_bank_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5
);
  import scan_bank_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  op_e              cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic [WIDTH-1:0] pdata;

  modport master (output cmd_valid, output cmd_op, output cmd_len, output pdata, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_len, input pdata, output cmd_ready);
endinterface

// File: rtl/scan_bank_ctrl_bank.sv
// Bank of mux-input flops: D0 parallel / D1 shift select, enable, synchronous clear.
module mux_ff_bank #(
  parameter int WIDTH = 16
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             sp,
  input  logic             sd,
  input  logic             cd,
  input  logic [WIDTH-1:0] d0,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d_sel;
  logic [WIDTH-1:0] q_reg;

  assign d1 = {q_reg[WIDTH-2:0], sin};

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mux
    assign d_sel[gi] = sd ? d1[gi] : d0[gi];
  end

  // Clear outranks the enable so a simultaneous CD/SP still yields zero.
  always_ff @(posedge ck) begin
    if (rst || cd) begin
      q_reg <= '0;
    end else if (sp) begin
      q_reg <= d_sel;
    end
  end

  assign q = q_reg;
endmodule

// File: rtl/scan_bank_ctrl.sv
// Command FSM and shift counter driving a mux_ff_bank; strobes decode from state only.
module scan_bank_ctrl
  import scan_bank_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             ck,
  input  logic             rst,
  scan_bank_ctrl_if.slave  cmd,
  input  logic             sin,
  output logic             sout,
  output logic [WIDTH-1:0] q,
  output logic             sp,
  output logic             sd,
  output logic             cd,
  output logic             done,
  output logic             busy
);
  state_e           state_reg, state_next;
  logic [LEN_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] pdata_reg, pdata_next;
  logic             accept;

  assign cmd.cmd_ready = (state_reg == ST_IDLE) && !rst;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pdata_next = pdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          pdata_next = cmd.pdata;
          case (cmd.cmd_op)
            OP_NOP:   state_next = ST_FIN;
            OP_CLEAR: state_next = ST_CLR;
            OP_LOAD:  state_next = ST_LD;
            OP_SHIFT: begin
              if (cmd.cmd_len == '0) begin
                state_next = ST_FIN;
              end else begin
                state_next = ST_SHF;
                cnt_next   = cmd.cmd_len;
              end
            end
            default:  state_next = ST_FIN;
          endcase
        end
      end
      ST_CLR:  state_next = ST_FIN;
      ST_LD:   state_next = ST_FIN;
      ST_SHF: begin
        // The count holds the shift cycles left including the current one.
        if (cnt_reg == LEN_W'(1)) begin
          state_next = ST_FIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - LEN_W'(1);
        end
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      pdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pdata_reg <= pdata_next;
    end
  end

  assign sp   = (state_reg == ST_LD) || (state_reg == ST_SHF);
  assign sd   = (state_reg == ST_SHF);
  assign cd   = (state_reg == ST_CLR);
  assign done = (state_reg == ST_FIN);
  assign busy = (state_reg != ST_IDLE);

  mux_ff_bank #(.WIDTH(WIDTH)) u_bank (
    .ck  (ck),
    .rst (rst),
    .sp  (sp),
    .sd  (sd),
    .cd  (cd),
    .d0  (pdata_reg),
    .sin (sin),
    .q   (q)
  );

  assign sout = q[WIDTH-1];
endmodule

// File: tb/tb_scan_bank_ctrl.sv
// Directed and random command sequences checked against a behavioural bank model.
module tb_scan_bank_ctrl;
  import scan_bank_pkg::*;

  localparam int W  = 16;
  localparam int LW = 5;

  logic         ck = 1'b0;
  logic         rst = 1'b1;
  logic         sin = 1'b0;
  logic         sout, sp, sd, cd, done, busy;
  logic [W-1:0] q;
  logic [W-1:0] q_model;
  int           checks = 0;
  int           errors = 0;

  always #5 ck = ~ck;

  scan_bank_ctrl_if #(.WIDTH(W), .LEN_W(LW)) bus ();

  scan_bank_ctrl #(.WIDTH(W), .LEN_W(LW)) dut (
    .ck   (ck),
    .rst  (rst),
    .cmd  (bus),
    .sin  (sin),
    .sout (sout),
    .q    (q),
    .sp   (sp),
    .sd   (sd),
    .cd   (cd),
    .done (done),
    .busy (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Issues one command, checks the strobes every busy cycle and the bank at DONE.
  task automatic run_cmd(input string name, input logic [1:0] op, input int len,
                         input logic [W-1:0] pd, input logic [31:0] bits, input bit hold);
    int  lat;
    int  waited;
    bit  fin;
    bit  busy_phase;
    @(negedge ck);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op_e'(op);
    bus.cmd_len   = LW'(len);
    bus.pdata     = pd;
    waited = 0;
    while (!bus.cmd_ready && waited < 50) begin
      @(negedge ck);
      waited++;
    end
    if (!bus.cmd_ready) begin
      chk({name, "_ready_timeout"}, {31'd0, bus.cmd_ready}, 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    if (op == 2'b00) lat = 1;
    else if (op == 2'b11) lat = (len == 0) ? 1 : len + 1;
    else lat = 2;

    @(negedge ck);
    if (hold) bus.cmd_op = OP_NOP;
    else bus.cmd_valid = 1'b0;
    bus.cmd_len = LW'($urandom);
    bus.pdata   = W'($urandom);

    for (int c = 1; c <= lat; c++) begin
      if (c > 1) @(negedge ck);
      fin = (c == lat);
      busy_phase = !fin;
      chk($sformatf("%s_ctl_c%0d", name, c),
          {26'd0, done, busy, bus.cmd_ready, sp, sd, cd},
          {26'd0, fin, 1'b1, 1'b0,
           busy_phase && (op == 2'b10 || op == 2'b11),
           busy_phase && (op == 2'b11),
           busy_phase && (op == 2'b01)});
      if (busy_phase && op == 2'b11) sin = bits[c-1];
      else sin = 1'($urandom);
    end

    case (op)
      2'b01: q_model = '0;
      2'b10: q_model = pd;
      2'b11: for (int i = 0; i < len; i++) q_model = {q_model[W-2:0], bits[i]};
      default: ;
    endcase
    chk({name, "_q"}, {16'd0, q}, {16'd0, q_model});
    chk({name, "_sout"}, {31'd0, sout}, {31'd0, q_model[W-1]});

    @(negedge ck);
    chk({name, "_idle"}, {29'd0, done, busy, bus.cmd_ready}, {29'd0, 1'b0, 1'b0, 1'b1});
    if (hold) begin
      @(negedge ck);
      chk({name, "_held_accept_done"}, {31'd0, done}, 32'd1);
      bus.cmd_valid = 1'b0;
      @(negedge ck);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_done;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_len   = '0;
    bus.pdata     = '0;
    q_model       = '0;

    repeat (3) @(negedge ck);
    chk("reset_outputs", {23'd0, q, sp, sd, cd, done, busy, bus.cmd_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("reset_release_ready", {31'd0, bus.cmd_ready}, 32'd1);

    run_cmd("load_a5c3", 2'b10, 0, 16'hA5C3, 32'd0, 1'b0);
    chk("load_a5c3_const", {16'd0, q}, 32'h0000_A5C3);

    run_cmd("shift4", 2'b11, 4, 16'h0000, 32'b1101, 1'b0);
    chk("shift4_const", {16'd0, q}, 32'h0000_5C3B);

    run_cmd("shift0", 2'b11, 0, 16'h1111, 32'hFFFF_FFFF, 1'b0);

    run_cmd("load_ffff", 2'b10, 0, 16'hFFFF, 32'd0, 1'b0);
    run_cmd("clear_hold", 2'b01, 0, 16'h0000, 32'd0, 1'b1);
    chk("clear_const", {16'd0, q}, 32'd0);

    run_cmd("shift20", 2'b11, 20, 16'h0000, 32'h000F_FFFF, 1'b0);
    chk("shift20_const", {16'd0, q}, 32'h0000_FFFF);

    // Reset during the third shift cycle of a 10-cycle shift.
    run_cmd("load_1234", 2'b10, 0, 16'h1234, 32'd0, 1'b0);
    @(negedge ck);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_SHIFT;
    bus.cmd_len   = LW'(10);
    @(negedge ck);
    bus.cmd_valid = 1'b0;
    sin = 1'b1;
    @(negedge ck);
    @(negedge ck);
    rst = 1'b1;
    @(negedge ck);
    chk("abort_state", {15'd0, q, done, busy, bus.cmd_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_ready_after", {31'd0, bus.cmd_ready}, 32'd1);
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge ck);
      seen_done |= done;
    end
    chk("abort_no_done", {31'd0, seen_done}, 32'd0);
    q_model = '0;

    for (int n = 0; n < 25; n++) begin
      logic [1:0] rop;
      int         rlen;
      rop  = 2'($urandom_range(0, 3));
      rlen = $urandom_range(0, 31);
      run_cmd($sformatf("rnd%0d", n), rop, rlen, W'($urandom), $urandom, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scan_bank_ctrl.md
SCAN_BANK_CTRL -- requirements
Module: scan_bank_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, number of mux-input flops in the controlled bank.
REQ-002 Parameter LEN_W, default 5, width of the shift-length field.
REQ-003 CK  input  1  clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 CMD_VALID  input  1  command offered.
REQ-006 CMD_READY  output  1  controller accepts a command this cycle.
REQ-007 CMD_OP  input  2  command: 00 NOP, 01 CLEAR, 10 LOAD, 11 SHIFT.
REQ-008 CMD_LEN  input  LEN_W  shift cycle count, SHIFT only.
REQ-009 PDATA  input  WIDTH  parallel load data, sampled at accept.
REQ-010 SIN  input  1  serial input, sampled every shift cycle.
REQ-011 SOUT  output  1  serial output, equal to Q[WIDTH-1].
REQ-012 Q  output  WIDTH  bank contents.
REQ-013 SP  output  1  bank clock-enable strobe (1 = update, 0 = hold).
REQ-014 SD  output  1  bank data select (0 = D0 parallel path, 1 = D1 shift path).
REQ-015 CD  output  1  bank clear strobe, synchronous.
REQ-016 DONE  output  1  one-cycle completion pulse.
REQ-017 BUSY  output  1  high from accept until the DONE cycle inclusive.

Function
REQ-018 States SHALL be IDLE, CLR, LD, SHF, FIN.
REQ-019 CMD_READY SHALL be 1 only in IDLE with RST low; accept = CMD_VALID & CMD_READY at a rising edge.
REQ-020 On accept, CMD_OP, CMD_LEN and PDATA SHALL be registered; later input changes SHALL not affect the command.
REQ-021 NOP: IDLE -> FIN; Q unchanged.
REQ-022 CLEAR: IDLE -> CLR for one cycle with CD=1, SP=0; Q=0 after that edge; CLR -> FIN.
REQ-023 LOAD: IDLE -> LD for one cycle with SP=1, SD=0; Q=registered PDATA after that edge; LD -> FIN.
REQ-024 SHIFT, LEN>0: IDLE -> SHF for exactly LEN cycles with SP=1, SD=1; each edge Q <= {Q[WIDTH-2:0], SIN}; SHF -> FIN when the remaining count reaches 1.
REQ-025 SHIFT, LEN=0: IDLE -> FIN directly; Q unchanged; SP never asserted.
REQ-026 LEN greater than WIDTH SHALL be honoured; shifting continues past full chain replacement.
REQ-027 FIN SHALL last one cycle with DONE=1, CMD_READY=0, then return to IDLE.
REQ-028 Total latency accept-to-DONE: NOP 1, CLEAR 2, LOAD 2, SHIFT(L>0) L+1 cycles; minimum command spacing is latency+1.
REQ-029 In IDLE and FIN, SP=SD=CD=0 and Q SHALL hold.
REQ-030 SP, SD, CD SHALL be decoded from registered state only; no combinational path from inputs.
REQ-031 CD SHALL take priority over SP in the bank (clear wins if both are asserted).

Reset
REQ-032 RST high at an edge SHALL force state IDLE, Q=0, SP=SD=CD=0, DONE=0, BUSY=0, counter=0.
REQ-033 CMD_READY SHALL be 0 while RST is high; no command is accepted in a reset cycle.
REQ-034 RST mid-command SHALL abort the command without DONE; the next cycle after RST deasserts is IDLE.

Structure
REQ-035 Package scan_bank_pkg SHALL hold the op encoding type, the state enum type and the default WIDTH/LEN_W constants.
REQ-036 The datapath SHALL be a sub-module mux_ff_bank: WIDTH flops, per-bit D0/D1 mux by SD, enable SP, sync clear CD; the FSM and counter stay in scan_bank_ctrl.

Verification
REQ-037 Reset, then LOAD PDATA=16'hA5C3 -> DONE 2 cycles after accept, Q=16'hA5C3, SOUT=1.
REQ-038 After Q=16'hA5C3, SHIFT LEN=4 with SIN=1,0,1,1 -> SP=SD=1 for exactly 4 cycles, Q=16'h5C3B, DONE at cycle 5.
REQ-039 SHIFT LEN=0 -> DONE 1 cycle after accept, SP never high, Q unchanged.
REQ-040 CLEAR with Q=16'hFFFF -> CD=1 for one cycle, Q=0, DONE 2 cycles after accept; CMD_VALID held high -> next accept no earlier than the cycle after DONE.
REQ-041 SHIFT LEN=20 from Q=0 with SIN=1 -> Q=16'hFFFF, DONE 21 cycles after accept.
REQ-042 RST asserted during the 3rd SHF cycle of LEN=10 -> no DONE, Q=0, CMD_READY=1 the cycle after RST falls.
